// File: rtl/button_conditioner.sv
// Multi-channel button/switch conditioner: two-flop synchroniser, saturating up/down
// integrator with hysteresis, rise/fall event pulses and optional auto-repeat per channel.
module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_EN      = 1,
  parameter int HOLD_CNT_MAX   = 500,
  parameter int REPEAT_CNT_MAX = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int TICK_W  = $clog2(SAMPLE_CNT_MAX);
  localparam int CNT_W   = $clog2(PULSE_CNT_MAX + 1);
  localparam int REP_MAX = (HOLD_CNT_MAX > REPEAT_CNT_MAX) ? HOLD_CNT_MAX : REPEAT_CNT_MAX;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]  sync_meta;
  logic [WIDTH-1:0]  s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      s         <= '0;
    end else begin
      sync_meta <= glitchy_signal;
      s         <= sync_meta;
    end
  end

  // One sample tick shared by every channel; restarts from 0 after reset.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             deb;
    logic             rise;
    logic             fall;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (cnt == CNT_TOP);
    assign at_bottom = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (tick) begin
        if (s[i] && !at_top) begin
          cnt <= cnt + CNT_W'(1);
        end else if (!s[i] && !at_bottom) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end

    // Level only flips at the integrator bounds, so mid-range counts keep the old level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb  <= 1'b0;
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        rise <= ~deb & at_top;
        fall <= deb & at_bottom;
        if (at_top) begin
          deb <= 1'b1;
        end else if (at_bottom) begin
          deb <= 1'b0;
        end
      end
    end

    assign debounced_signal[i] = deb;
    assign rise_pulse[i]       = rise;
    assign fall_pulse[i]       = fall;

    if (REPEAT_EN != 0) begin : g_rep
      localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CNT_MAX - 1);
      localparam logic [REP_W-1:0] RPT_LAST  = REP_W'(REPEAT_CNT_MAX - 1);

      logic [REP_W-1:0] rep_cnt;
      logic             armed;
      logic             rep;

      // First repeat waits the long hold interval; once armed, the shorter interval applies.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt <= '0;
          armed   <= 1'b0;
          rep     <= 1'b0;
        end else begin
          rep <= 1'b0;
          if (!deb) begin
            rep_cnt <= '0;
            armed   <= 1'b0;
          end else if (tick) begin
            if (rep_cnt == (armed ? RPT_LAST : HOLD_LAST)) begin
              rep     <= 1'b1;
              rep_cnt <= '0;
              armed   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
      end

      assign repeat_pulse[i] = rep;
    end else begin : g_norep
      assign repeat_pulse[i] = 1'b0;
    end
  end

endmodule
